// File: rtl/simd_lane_exec_pipe.sv
// SIMD execute unit: LANES x LANE_W masked ops (optional unsigned saturation), result after STAGES cycles.
// Valid/ready pipeline, bubbles collapse, out_ready gates the tail; flush/reset kill every in-flight beat.
module simd_lane_exec_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic                    sat,
  input  logic [LANES-1:0]        mask,
  input  logic [LANES*LANE_W-1:0] srca,
  input  logic [LANES*LANE_W-1:0] srcb,
  input  logic [TAG_W-1:0]        tag_in,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result,
  output logic [LANES-1:0]        ovf,
  output logic [TAG_W-1:0]        tag_out
);

  localparam int DW = LANES * LANE_W;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_MINU  = 3'b101;
  localparam logic [2:0] OP_MAXU  = 3'b110;
  localparam logic [2:0] OP_MULLO = 3'b111;

  logic [DW-1:0]    comp_res;
  logic [LANES-1:0] comp_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0]   a, b, r;
    logic                o;
    logic [LANE_W:0]     sum;
    logic [2*LANE_W-1:0] prod;

    assign a    = srca[i*LANE_W +: LANE_W];
    assign b    = srcb[i*LANE_W +: LANE_W];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {{LANE_W{1'b0}}, a} * {{LANE_W{1'b0}}, b};

    always_comb begin
      r = a;
      o = 1'b0;
      if (mask[i]) begin
        case (op)
          OP_ADD: begin
            o = sum[LANE_W];
            r = (sat && o) ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
          end
          OP_SUB: begin
            o = (a < b);
            r = (sat && o) ? {LANE_W{1'b0}} : a - b;
          end
          OP_AND:  r = a & b;
          OP_OR:   r = a | b;
          OP_XOR:  r = a ^ b;
          OP_MINU: r = (a < b) ? a : b;
          OP_MAXU: r = (a < b) ? b : a;
          OP_MULLO: begin
            o = |prod[2*LANE_W-1:LANE_W];
            r = (sat && o) ? {LANE_W{1'b1}} : prod[LANE_W-1:0];
          end
          default: r = a;
        endcase
      end
    end

    assign comp_res[i*LANE_W +: LANE_W] = r;
    assign comp_ovf[i]                  = o;
  end

  logic [STAGES-1:0]           vld;
  logic [STAGES-1:0]           adv;
  logic [STAGES-1:0][DW-1:0]   res_q;
  logic [STAGES-1:0][LANES-1:0] ovf_q;
  logic [STAGES-1:0][TAG_W-1:0] tag_q;

  // Advance chain resolved tail-first so a draining tail lets a full pipe accept every cycle.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld[k] || adv[k+1];
    end
  end

  assign in_ready = !flush && adv[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld   <= '0;
      res_q <= '0;
      ovf_q <= '0;
      tag_q <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (adv[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          res_q[0] <= comp_res;
          ovf_q[0] <= comp_ovf;
          tag_q[0] <= tag_in;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k]) begin
          vld[k] <= vld[k-1];
          // Data only moves with a real beat, so the tail keeps its last result across bubbles.
          if (vld[k-1]) begin
            res_q[k] <= res_q[k-1];
            ovf_q[k] <= ovf_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign result    = res_q[STAGES-1];
  assign ovf       = ovf_q[STAGES-1];
  assign tag_out   = tag_q[STAGES-1];

endmodule

// File: tb/tb_simd_lane_exec_pipe.sv
// Scoreboard bench for simd_lane_exec_pipe (4 lanes x 8 bits, 2 stages) with hand-computed vectors.
module tb_simd_lane_exec_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic        sat;
  logic [3:0]  mask;
  logic [31:0] srca, srcb;
  logic [4:0]  tag_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  ovf;
  logic [4:0]  tag_out;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  ovf;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  simd_lane_exec_pipe #(.LANES(4), .LANE_W(8), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .sat(sat), .mask(mask), .srca(srca), .srcb(srcb), .tag_in(tag_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: a beat is delivered on the edge following a negedge that sees out_valid && out_ready.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got res=%h ovf=%b tag=%0d with nothing outstanding",
                 result, ovf, tag_out);
      end else begin
        e = exp_q.pop_front();
        if (result !== e.res || ovf !== e.ovf || tag_out !== e.tag) begin
          failures++;
          $display("FAIL beat_tag%0d: got res=%h ovf=%b tag=%0d expected res=%h ovf=%b tag=%0d",
                   e.tag, result, ovf, tag_out, e.res, e.ovf, e.tag);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic s, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                       input logic [31:0] er, input logic [3:0] eo);
    bit acc = 0;
    in_valid = 1'b1; op = o; sat = s; mask = m; srca = a; srcb = b; tag_in = t;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{res: er, ovf: eo, tag: t});
        acc = 1;
        break;
      end
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL issue_timeout: tag %0d got no in_ready within 200 cycles, expected acceptance", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'b000; sat = 1'b0; mask = 4'h0;
    srca = '0; srcb = '0; tag_in = '0; flush = 1'b0; out_ready = 1'b1;
    cycles(2);
    reset = 1'b0;
    @(negedge clk);
    check32("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check32("reset_result", result, 32'h0);
    check32("reset_ovf", {28'b0, ovf}, 32'd0);
    check32("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // ADD wrapping, with latency probe: empty one cycle after acceptance, valid the next.
    issue(3'b000, 1'b0, 4'hF, 32'hF0107F01, 32'h201001FF, 5'd1, 32'h10208000, 4'b1001);
    @(negedge clk);
    check32("latency_early", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check32("latency_ontime", {31'b0, out_valid}, 32'd1);
    cycles(2);

    // Back-to-back table with a fixed out_ready stall pattern running alongside.
    fork
      begin
        issue(3'b000, 1'b1, 4'hF, 32'hF0107F01, 32'h201001FF, 5'd2,  32'hFF2080FF, 4'b1001);
        issue(3'b001, 1'b1, 4'h5, 32'h05050505, 32'h0A0A0A0A, 5'd7,  32'h05000500, 4'b0101);
        issue(3'b001, 1'b0, 4'hF, 32'h00108005, 32'h01107F0A, 5'd3,  32'hFF0001FB, 4'b1001);
        issue(3'b111, 1'b0, 4'hF, 32'h1003FF02, 32'h10050280, 5'd4,  32'h000FFE00, 4'b1011);
        issue(3'b111, 1'b1, 4'hF, 32'h1003FF02, 32'h10050280, 5'd5,  32'hFF0FFFFF, 4'b1011);
        issue(3'b101, 1'b1, 4'hF, 32'h8001FF10, 32'h7F02FF20, 5'd6,  32'h7F01FF10, 4'b0000);
        issue(3'b110, 1'b0, 4'hF, 32'h8001FF10, 32'h7F02FF20, 5'd8,  32'h8002FF20, 4'b0000);
        issue(3'b010, 1'b0, 4'hF, 32'hF0AA0FFF, 32'h3C55FF00, 5'd9,  32'h30000F00, 4'b0000);
        issue(3'b011, 1'b0, 4'hF, 32'hF0AA0FFF, 32'h3C55FF00, 5'd10, 32'hFCFFFFFF, 4'b0000);
        issue(3'b100, 1'b0, 4'hA, 32'hF0AA0FFF, 32'h3C55FF00, 5'd11, 32'hCCAAF0FF, 4'b0000);
        issue(3'b000, 1'b1, 4'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF, 4'b0000);
      end
      begin
        logic [15:0] pat;
        pat = 16'b1011_0010_1101_0110;
        for (int i = 0; i < 16; i++) begin
          out_ready = pat[i];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    cycles(6);

    // Full pipe under stall: third beat refused, head result held, then drains in order.
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 4'hF, 32'h01020304, 32'h10101010, 5'd13, 32'h11121314, 4'b0000);
    issue(3'b011, 1'b0, 4'hF, 32'h01020304, 32'h10101010, 5'd14, 32'h11121314, 4'b0000);
    in_valid = 1'b1; op = 3'b100; sat = 1'b0; mask = 4'hF;
    srca = 32'h01020304; srcb = 32'h10101010; tag_in = 5'd15;
    @(negedge clk);
    check32("full_in_ready", {31'b0, in_ready}, 32'd0);
    check32("hold_result_1", result, 32'h11121314);
    check32("hold_tag_1", {27'b0, tag_out}, 32'd13);
    @(posedge clk); #1;
    @(negedge clk);
    check32("hold_result_2", result, 32'h11121314);
    check32("hold_valid_2", {31'b0, out_valid}, 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(3'b100, 1'b0, 4'hF, 32'h01020304, 32'h10101010, 5'd15, 32'h11121314, 4'b0000);
    cycles(5);

    // Flush: two beats in flight, flush with a beat offered; nothing emerges afterwards.
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 4'hF, 32'h11111111, 32'h22222222, 5'd20, 32'h33333333, 4'b0000);
    issue(3'b000, 1'b0, 4'hF, 32'h44444444, 32'h11111111, 5'd21, 32'h55555555, 4'b0000);
    in_valid = 1'b1; tag_in = 5'd22; flush = 1'b1;
    @(negedge clk);
    check32("flush_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check32("flush_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(4);
    issue(3'b001, 1'b0, 4'hF, 32'h10203040, 32'h01020304, 5'd23, 32'h0F1E2D3C, 4'b0000);
    cycles(4);

    // Reset mid-stream discards in-flight beats.
    out_ready = 1'b0;
    issue(3'b000, 1'b0, 4'hF, 32'h01010101, 32'h01010101, 5'd24, 32'h02020202, 4'b0000);
    issue(3'b000, 1'b0, 4'hF, 32'h02020202, 32'h01010101, 5'd25, 32'h03030303, 4'b0000);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check32("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check32("midreset_result", result, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(4);
    issue(3'b110, 1'b0, 4'h3, 32'h01020304, 32'h04030201, 5'd26, 32'h01020304, 4'b0000);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check32("drain_outstanding", exp_q.size(), 32'd0);
    end
    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
